// File: rtl/datapath_sequencer.sv
// rtl/datapath_sequencer.sv - Moore control sequencer for fetch and register-register ALU ops on a shared bus
//
// Ports:
//   clock, reset_n                      rising-edge clock, synchronous active-low reset
//   run                                 level; high keeps fetching/executing instructions
//   ir[31:0]                            instruction register: op=ir[31:27], ra, rb, rc below it
//   mem_ready                           memory read data valid this cycle
//   PCout, Zhighout, Zlowout, MDRout,
//   Rout                                bus source enables (at most one per cycle)
//   reg_sel                             register index for Rout/Rin
//   PCin, MARin, MDRin, IRin, Yin, Zin,
//   Rin, HIin, LOin                     register load enables
//   IncPC, Read, alu_op                 ALU/memory controls
//   done, illegal                       one-cycle retire / undefined-opcode pulses
//   mem_err                             sticky memory wait-limit error

module datapath_sequencer #(
    parameter int OPW     = 5,
    parameter int REGW    = 4,
    parameter int MAXWAIT = 15
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            run,
    input  logic [31:0]     ir,
    input  logic            mem_ready,
    output logic            PCout,
    output logic            Zhighout,
    output logic            Zlowout,
    output logic            MDRout,
    output logic            Rout,
    output logic [REGW-1:0] reg_sel,
    output logic            PCin,
    output logic            MARin,
    output logic            MDRin,
    output logic            IRin,
    output logic            Yin,
    output logic            Zin,
    output logic            Rin,
    output logic            HIin,
    output logic            LOin,
    output logic            IncPC,
    output logic            Read,
    output logic [2:0]      alu_op,
    output logic            done,
    output logic            illegal,
    output logic            mem_err
);

    localparam int WW = $clog2(MAXWAIT + 1);

    // Bus source order: {PCout, Zhighout, Zlowout, MDRout, Rout}
    localparam logic [4:0] B_PC  = 5'b10000;
    localparam logic [4:0] B_ZH  = 5'b01000;
    localparam logic [4:0] B_ZL  = 5'b00100;
    localparam logic [4:0] B_MDR = 5'b00010;
    localparam logic [4:0] B_R   = 5'b00001;

    // Load order: {PCin, MARin, MDRin, IRin, Yin, Zin, Rin, HIin, LOin}
    localparam logic [8:0] L_NONE = 9'b0_0000_0000;
    localparam logic [8:0] L_PC   = 9'b1_0000_0000;
    localparam logic [8:0] L_MAR  = 9'b0_1000_0000;
    localparam logic [8:0] L_MDR  = 9'b0_0100_0000;
    localparam logic [8:0] L_IR   = 9'b0_0010_0000;
    localparam logic [8:0] L_Y    = 9'b0_0001_0000;
    localparam logic [8:0] L_Z    = 9'b0_0000_1000;
    localparam logic [8:0] L_R    = 9'b0_0000_0100;
    localparam logic [8:0] L_HI   = 9'b0_0000_0010;
    localparam logic [8:0] L_LO   = 9'b0_0000_0001;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_RET
    } state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            err_q, err_d;
    logic [4:0]      bus_q;
    logic [8:0]      ld_q;
    logic            inc_q, read_q, done_q;
    logic [2:0]      alu_q;

    logic [OPW-1:0]  op;
    logic [REGW-1:0] ra, rb, rc;
    logic            op_illegal, op_md;
    logic            unused_ir_bits;

    assign op = ir[31 -: OPW];
    assign ra = ir[31-OPW -: REGW];
    assign rb = ir[31-OPW-REGW -: REGW];
    assign rc = ir[31-OPW-2*REGW -: REGW];
    assign unused_ir_bits = ^ir[31-OPW-3*REGW:0];

    assign op_illegal = (op > OPW'(5));
    assign op_md      = (op == OPW'(4)) || (op == OPW'(5));

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: if (run && !err_q) state_d = S_T0;
            S_T0: begin
                state_d = S_T1;
                wait_d  = '0;
            end
            S_T1: begin
                if (mem_ready) begin
                    state_d = S_T2;
                    wait_d  = '0;
                end else if (wait_q == WW'(MAXWAIT - 1)) begin
                    // Wait limit reached: park in IDLE; err_q keeps run ignored until reset.
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                    wait_d  = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_T2:    state_d = S_T3;
            S_T3:    state_d = op_illegal ? S_RET : S_T4;
            S_T4:    state_d = S_T5;
            S_T5:    state_d = op_md ? S_T6 : S_RET;
            S_T6:    state_d = S_RET;
            S_RET:   state_d = run ? S_T0 : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the state being entered, so they line up with state_q.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            err_q   <= 1'b0;
            bus_q   <= '0;
            ld_q    <= L_NONE;
            inc_q   <= 1'b0;
            read_q  <= 1'b0;
            done_q  <= 1'b0;
            alu_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            bus_q   <= '0;
            ld_q    <= L_NONE;
            inc_q   <= 1'b0;
            read_q  <= 1'b0;
            done_q  <= 1'b0;
            alu_q   <= '0;
            case (state_d)
                S_T0: begin
                    bus_q <= B_PC;
                    ld_q  <= L_MAR | L_Z;
                    inc_q <= 1'b1;
                    alu_q <= 3'd7;
                end
                S_T1: begin
                    bus_q  <= B_ZL;
                    // PC loads only on entry; wait-state cycles must not re-load it.
                    ld_q   <= L_MDR | ((state_q == S_T0) ? L_PC : L_NONE);
                    read_q <= 1'b1;
                end
                S_T2: begin
                    bus_q <= B_MDR;
                    ld_q  <= L_IR;
                end
                S_T3: begin
                    bus_q <= B_R;
                    ld_q  <= L_Y;
                end
                S_T4: begin
                    bus_q <= B_R;
                    ld_q  <= L_Z;
                    alu_q <= op[2:0];
                end
                S_T5: begin
                    bus_q <= B_ZL;
                    ld_q  <= op_md ? L_LO : L_R;
                end
                S_T6: begin
                    bus_q <= B_ZH;
                    ld_q  <= L_HI;
                end
                // RET is reached from T3 only for an illegal opcode, which does not retire.
                S_RET:   done_q <= (state_q != S_T3);
                default: ;
            endcase
        end
    end

    // reg_sel and illegal depend on IR fields that only become valid once T3 is
    // entered (IR loads at the end of T2), so they are decoded from the current state.
    always_comb begin
        reg_sel = '0;
        illegal = 1'b0;
        case (state_q)
            S_T3: begin
                reg_sel = rb;
                illegal = op_illegal;
            end
            S_T4:    reg_sel = rc;
            S_T5:    reg_sel = op_md ? '0 : ra;
            default: ;
        endcase
    end

    assign {PCout, Zhighout, Zlowout, MDRout, Rout} = bus_q;
    assign {PCin, MARin, MDRin, IRin, Yin, Zin, Rin, HIin, LOin} = ld_q;
    assign IncPC   = inc_q;
    assign Read    = read_q;
    assign alu_op  = alu_q;
    assign done    = done_q;
    assign mem_err = err_q;

    a_bus_exclusive: assert property (@(posedge clock)
        $onehot0({PCout, Zhighout, Zlowout, MDRout, Rout}));

endmodule

// File: tb/tb_datapath_sequencer.sv
// tb/tb_datapath_sequencer.sv - table-driven and randomized-instruction bench for datapath_sequencer

module tb_datapath_sequencer;

    logic        clock = 1'b0;
    logic        reset_n, run, mem_ready;
    logic [31:0] ir;
    logic        PCout, Zhighout, Zlowout, MDRout, Rout;
    logic [3:0]  reg_sel;
    logic        PCin, MARin, MDRin, IRin, Yin, Zin, Rin, HIin, LOin;
    logic        IncPC, Read, done, illegal, mem_err;
    logic [2:0]  alu_op;

    datapath_sequencer dut (
        .clock(clock), .reset_n(reset_n), .run(run), .ir(ir), .mem_ready(mem_ready),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout), .Rout(Rout),
        .reg_sel(reg_sel),
        .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .Rin(Rin), .HIin(HIin), .LOin(LOin),
        .IncPC(IncPC), .Read(Read), .alu_op(alu_op),
        .done(done), .illegal(illegal), .mem_err(mem_err)
    );

    always #5 clock = ~clock;

    localparam logic [4:0] B_PC = 5'b10000, B_ZH = 5'b01000, B_ZL = 5'b00100,
                           B_MDR = 5'b00010, B_R = 5'b00001;
    localparam logic [8:0] L_PC = 9'h100, L_MAR = 9'h080, L_MDR = 9'h040, L_IR = 9'h020,
                           L_Y = 9'h010, L_Z = 9'h008, L_R = 9'h004, L_HI = 9'h002, L_LO = 9'h001;
    localparam logic [4:0] M_INC = 5'b10000, M_RD = 5'b01000, M_DONE = 5'b00100,
                           M_ILL = 5'b00010, M_ERR = 5'b00001;

    typedef struct {
        logic        rst_n;
        logic        run;
        logic        rdy;
        logic [31:0] ir;
        logic [25:0] exp;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    logic [25:0] act;
    assign act = {PCout, Zhighout, Zlowout, MDRout, Rout,
                  PCin, MARin, MDRin, IRin, Yin, Zin, Rin, HIin, LOin,
                  IncPC, Read, done, illegal, mem_err, reg_sel, alu_op};

    logic [25:0] X_T0, X_T1F, X_T1W, X_T2, X_RET, X_ERR;
    logic [31:0] I_ADD, I_MUL, I_ILL, I_SUB;

    function automatic logic [25:0] ex(input logic [4:0] b, input logic [8:0] l,
                                       input logic [4:0] m, input logic [3:0] sel,
                                       input logic [2:0] op);
        return {b, l, m, sel, op};
    endfunction

    function automatic logic [31:0] mkir(input logic [4:0] op, input logic [3:0] a,
                                         input logic [3:0] b, input logic [3:0] c);
        return {op, a, b, c, 15'd0};
    endfunction

    task automatic add(input logic r, input logic ru, input logic rd,
                       input logic [31:0] i, input logic [25:0] e);
        vec_t v;
        v.rst_n = r; v.run = ru; v.rdy = rd; v.ir = i; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [25:0] got, input logic [25:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    int op, w, len, total, cnt_done, exp_done_cnt;
    logic exp_d, exp_i;

    initial begin
        X_T0  = ex(B_PC, L_MAR | L_Z, M_INC, 4'd0, 3'd7);
        X_T1F = ex(B_ZL, L_PC | L_MDR, M_RD, 4'd0, 3'd0);
        X_T1W = ex(B_ZL, L_MDR, M_RD, 4'd0, 3'd0);
        X_T2  = ex(B_MDR, L_IR, 5'd0, 4'd0, 3'd0);
        X_RET = ex(5'd0, 9'd0, M_DONE, 4'd0, 3'd0);
        X_ERR = ex(5'd0, 9'd0, M_ERR, 4'd0, 3'd0);
        I_ADD = 32'h0091_8000;
        I_MUL = mkir(5'd4, 4'd7, 4'd5, 4'd6);
        I_ILL = mkir(5'h1F, 4'd3, 4'd1, 4'd2);
        I_SUB = mkir(5'd1, 4'd4, 4'd5, 4'd6);

        // reset held with run=1, then add R1,R2,R3 with no wait states
        for (int i = 0; i < 3; i++) add(0, 1, 1, I_ADD, 26'd0);
        add(1, 1, 1, I_ADD, X_T0);
        add(1, 1, 1, I_ADD, X_T1F);
        add(1, 1, 1, I_ADD, X_T2);
        add(1, 1, 1, I_ADD, ex(B_R, L_Y, 5'd0, 4'd2, 3'd0));
        add(1, 1, 1, I_ADD, ex(B_R, L_Z, 5'd0, 4'd3, 3'd0));
        add(1, 1, 1, I_ADD, ex(B_ZL, L_R, 5'd0, 4'd1, 3'd0));
        add(1, 1, 1, I_ADD, X_RET);
        // mul: eight cycles, LO then HI, never Rin
        add(1, 1, 1, I_MUL, X_T0);
        add(1, 1, 1, I_MUL, X_T1F);
        add(1, 1, 1, I_MUL, X_T2);
        add(1, 1, 1, I_MUL, ex(B_R, L_Y, 5'd0, 4'd5, 3'd0));
        add(1, 1, 1, I_MUL, ex(B_R, L_Z, 5'd0, 4'd6, 3'd4));
        add(1, 1, 1, I_MUL, ex(B_ZL, L_LO, 5'd0, 4'd0, 3'd0));
        add(1, 1, 1, I_MUL, ex(B_ZH, L_HI, 5'd0, 4'd0, 3'd0));
        add(1, 1, 1, I_MUL, X_RET);
        // illegal opcode: pulse in T3, straight to a silent RET, then next fetch
        add(1, 1, 1, I_ILL, X_T0);
        add(1, 1, 1, I_ILL, X_T1F);
        add(1, 1, 1, I_ILL, X_T2);
        add(1, 1, 1, I_ILL, ex(B_R, L_Y, M_ILL, 4'd1, 3'd0));
        add(1, 1, 1, I_ILL, 26'd0);
        // sub with three wait states, run dropped mid-instruction
        add(1, 1, 1, I_SUB, X_T0);
        add(1, 1, 0, I_SUB, X_T1F);
        for (int i = 0; i < 3; i++) add(1, 1, 0, I_SUB, X_T1W);
        add(1, 1, 1, I_SUB, X_T2);
        add(1, 1, 1, I_SUB, ex(B_R, L_Y, 5'd0, 4'd5, 3'd0));
        add(1, 0, 1, I_SUB, ex(B_R, L_Z, 5'd0, 4'd6, 3'd1));
        add(1, 0, 1, I_SUB, ex(B_ZL, L_R, 5'd0, 4'd4, 3'd0));
        add(1, 0, 1, I_SUB, X_RET);
        add(1, 0, 1, I_SUB, 26'd0);
        add(1, 0, 1, I_SUB, 26'd0);
        // memory never ready: 15 low samples in T1 trip mem_err and lock out run
        add(1, 1, 0, I_SUB, X_T0);
        add(1, 1, 0, I_SUB, X_T1F);
        for (int i = 0; i < 14; i++) add(1, 1, 0, I_SUB, X_T1W);
        add(1, 1, 0, I_SUB, X_ERR);
        add(1, 1, 1, I_SUB, X_ERR);
        add(1, 1, 1, I_SUB, X_ERR);
        // reset clears mem_err; reset mid-instruction wins
        add(0, 1, 1, I_ADD, 26'd0);
        add(1, 1, 1, I_ADD, X_T0);
        add(1, 1, 1, I_ADD, X_T1F);
        add(0, 1, 1, I_ADD, 26'd0);
        add(1, 0, 1, I_ADD, 26'd0);

        reset_n = 1'b0; run = 1'b0; mem_ready = 1'b0; ir = '0;
        #1;
        foreach (vq[i]) begin
            reset_n   = vq[i].rst_n;
            run       = vq[i].run;
            mem_ready = vq[i].rdy;
            ir        = vq[i].ir;
            @(posedge clock);
            #1;
            check($sformatf("vec%0d", i), act, vq[i].exp);
        end

        // randomized instruction stream with back-to-back fetches and random waits
        reset_n = 1'b0; run = 1'b1; mem_ready = 1'b1;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cnt_done = 0;
        exp_done_cnt = 0;
        for (int k = 0; k < 300; k++) begin
            op = int'($urandom_range(0, 7));
            if (k % 17 == 0) op = 31;
            w  = int'($urandom_range(0, 3));
            ir = mkir(5'(op), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)));
            len   = (op <= 3) ? 7 : (op <= 5) ? 8 : 5;
            total = len + w;
            if (op <= 5) exp_done_cnt++;
            for (int j = 1; j <= total; j++) begin
                if (j >= 3 && j <= 2 + w) mem_ready = 1'b0;
                else if (j == 3 + w)      mem_ready = 1'b1;
                else                      mem_ready = 1'($urandom_range(0, 1));
                @(posedge clock);
                #1;
                exp_d = (j == total) && (op <= 5);
                exp_i = (j == 4 + w) && (op > 5);
                if (done) cnt_done++;
                check($sformatf("rand%0d_%0d", k, j),
                      {23'd0, $onehot0({PCout, Zhighout, Zlowout, MDRout, Rout}), done, illegal},
                      {23'd0, 1'b1, exp_d, exp_i});
            end
        end
        check("done_count", 26'(cnt_done), 26'(exp_done_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
